// File: rtl/round_robin_arbiter_8.sv
// Eight-requester round-robin arbiter with a per-ownership hold limit.
// The winner is found by scanning the request vector from a rotating
// pointer, wrapping 7->0. An owner keeps the grant while it requests, up to
// MAX_HOLD consecutive cycles (0 = unlimited). Then the pointer moves past
// it and arbitration runs again in the same edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant outstanding, outputs zero
// GRANT | owner_q holds the resource, hold counter counts its cycles
module round_robin_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       Clock_In,
   input  logic       Reset_n_In,
   input  logic       Enable_In,
   input  logic [7:0] Request_In,
   output logic [7:0] Grant_Out,
   output logic [2:0] Grant_Index_Out,
   output logic       Grant_Valid_Out
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // The hold counter is 8 bits wide, so only the low byte of MAX_HOLD is used.
   localparam logic [7:0] MAX_HOLD_C  = MAX_HOLD[7:0];
   localparam logic       UNLIMITED_C = (MAX_HOLD == 0);

   state_t     state_q, state_d;
   logic [2:0] owner_q, owner_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] index_q, index_d;
   logic       valid_q, valid_d;

   logic [2:0] rel_ptr;
   logic [3:0] pick_idle;
   logic [3:0] pick_rot;
   logic       hold_ok;

   // Returns {found, index}. The search starts at 'start' and wraps 7->0.
   // The loop runs from the farthest offset down to the nearest, so the
   // requester closest to 'start' writes the result last and wins.
   function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = start + 3'(k);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // State register: synchronous active-low reset clears everything at the edge.
   always_ff @(posedge Clock_In) begin
      if (!Reset_n_In) begin
         state_q <= IDLE;
         owner_q <= 3'd0;
         ptr_q   <= 3'd0;
         cnt_q   <= 8'd0;
         grant_q <= 8'd0;
         index_q <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         index_q <= index_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic. Disable wins over release/timeout, which wins over hold.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      rel_ptr   = owner_q + 3'd1;
      pick_idle = pick(Request_In, ptr_q);
      pick_rot  = pick(Request_In, rel_ptr);
      hold_ok   = Request_In[owner_q] && (UNLIMITED_C || (cnt_q < MAX_HOLD_C));

      if (!Enable_In) begin
         // The pointer is kept so that re-enabling resumes the rotation.
         state_d = IDLE;
         owner_d = 3'd0;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               // Entering from IDLE does not move the pointer.
               if (pick_idle[3]) begin
                  state_d = GRANT;
                  owner_d = pick_idle[2:0];
                  cnt_d   = 8'd1;
               end
            end
            GRANT: begin
               if (hold_ok) begin
                  if (cnt_q != 8'hFF) begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  // Release or timeout. A timed-out owner that still requests
                  // takes part again and wins if nobody else is asking.
                  ptr_d = rel_ptr;
                  if (pick_rot[3]) begin
                     owner_d = pick_rot[2:0];
                     cnt_d   = 8'd1;
                  end else begin
                     state_d = IDLE;
                     owner_d = 3'd0;
                     cnt_d   = 8'd0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               owner_d = 3'd0;
               cnt_d   = 8'd0;
            end
         endcase
      end

      // Register the decoded outputs so downstream mux selects come straight from flops.
      grant_d = (state_d == GRANT) ? (8'd1 << owner_d) : 8'd0;
      index_d = (state_d == GRANT) ? owner_d : 3'd0;
      valid_d = (state_d == GRANT);
   end

   // Output logic: ports are driven directly by the registered grant image.
   always_comb begin
      Grant_Out       = grant_q;
      Grant_Index_Out = index_q;
      Grant_Valid_Out = valid_q;
   end

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Bench for round_robin_arbiter_8 with MAX_HOLD=4. A behavioural model runs
// alongside the DUT. Directed scenarios also check explicit grant values,
// and a random phase follows.
module tb_round_robin_arbiter_8;

   localparam int MAXH = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] gidx;
   logic       gvalid;

   int checks = 0;
   int errors = 0;

   // reference model state: owner -1 means no grant
   int m_ptr   = 0;
   int m_owner = -1;
   int m_cnt   = 0;

   round_robin_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
      .Clock_In        (clk),
      .Reset_n_In      (rst_n),
      .Enable_In       (en),
      .Request_In      (req),
      .Grant_Out       (grant),
      .Grant_Index_Out (gidx),
      .Grant_Valid_Out (gvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int first_from(input int start, input logic [7:0] r);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic rn, input logic e, input logic [7:0] r);
      int w;
      if (!rn) begin
         m_ptr = 0; m_owner = -1; m_cnt = 0;
      end else if (!e) begin
         m_owner = -1; m_cnt = 0;
      end else if (m_owner < 0) begin
         w = first_from(m_ptr, r);
         if (w >= 0) begin
            m_owner = w; m_cnt = 1;
         end
      end else if (r[m_owner] && m_cnt < MAXH) begin
         m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end else begin
         m_ptr = (m_owner + 1) % 8;
         w = first_from(m_ptr, r);
         m_owner = w;
         m_cnt = (w >= 0) ? 1 : 0;
      end
   endtask

   // Apply one cycle of inputs, advance the model and compare all outputs.
   task automatic step(input logic rn, input logic e, input logic [7:0] r, input string tag);
      logic [7:0] eg;
      logic [2:0] ei;
      logic       ev;
      @(negedge clk);
      rst_n = rn; en = e; req = r;
      model_edge(rn, e, r);
      @(posedge clk);
      #1;
      eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      ev = (m_owner >= 0);
      checks++;
      assert (grant === eg) else begin
         errors++;
         $error("FAIL %s grant: observed %h expected %h", tag, grant, eg);
      end
      checks++;
      assert (gidx === ei) else begin
         errors++;
         $error("FAIL %s index: observed %0d expected %0d", tag, gidx, ei);
      end
      checks++;
      assert (gvalid === ev) else begin
         errors++;
         $error("FAIL %s valid: observed %b expected %b", tag, gvalid, ev);
      end
   endtask

   // Scenario-level check against a hand-derived constant.
   task automatic expect_grant(input logic [7:0] exp, input string tag);
      checks++;
      assert (grant === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, grant, exp);
      end
   endtask

   initial begin
      logic [7:0] r;
      logic       e;
      logic       rn;
      rst_n = 1'b0; en = 1'b1; req = 8'hFF;

      // reset then idle
      step(1'b0, 1'b1, 8'hFF, "reset0");
      step(1'b0, 1'b1, 8'hFF, "reset1");
      expect_grant(8'h00, "reset_outputs");
      step(1'b1, 1'b1, 8'hFF, "first_grant");
      expect_grant(8'h01, "first_grant_req0");

      // fixed-then-rotate
      step(1'b0, 1'b1, 8'h00, "rot_reset");
      step(1'b1, 1'b1, 8'hA4, "rot_g2a");
      expect_grant(8'h04, "rot_grant2");
      step(1'b1, 1'b1, 8'hA4, "rot_g2b");
      step(1'b1, 1'b1, 8'hA4, "rot_g2c");
      expect_grant(8'h04, "rot_grant2_held");
      step(1'b1, 1'b1, 8'hA0, "rot_g5a");
      expect_grant(8'h20, "rot_grant5_b2b");
      step(1'b1, 1'b1, 8'hA0, "rot_g5b");
      step(1'b1, 1'b1, 8'h80, "rot_g7a");
      expect_grant(8'h80, "rot_grant7");
      step(1'b1, 1'b1, 8'h80, "rot_g7b");
      step(1'b1, 1'b1, 8'h04, "rot_wrap");
      expect_grant(8'h04, "rot_wrap_grant2");

      // timeout alternation
      step(1'b0, 1'b1, 8'h00, "to_reset");
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 8'h09, "timeout");
         expect_grant(((i / 4) % 2 == 0) ? 8'h01 : 8'h08, "timeout_seq");
      end

      // sole requester keeps the grant across timeouts
      step(1'b0, 1'b1, 8'h00, "sole_reset");
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 8'h40, "sole");
         expect_grant(8'h40, "sole_no_bubble");
      end

      // enable handling and mid-grant reset
      step(1'b0, 1'b1, 8'h00, "en_reset");
      step(1'b1, 1'b1, 8'h04, "en_g2");
      step(1'b1, 1'b1, 8'h08, "en_g3");
      expect_grant(8'h08, "en_grant3");
      step(1'b1, 1'b0, 8'h08, "en_off");
      expect_grant(8'h00, "en_off_zero");
      step(1'b1, 1'b1, 8'h18, "en_on");
      expect_grant(8'h08, "en_resume3");
      step(1'b1, 1'b0, 8'h18, "en_off2");
      step(1'b1, 1'b1, 8'h09, "en_ptr_held");
      expect_grant(8'h08, "en_ptr_held3");
      step(1'b0, 1'b1, 8'h09, "mid_reset");
      expect_grant(8'h00, "mid_reset_zero");
      step(1'b1, 1'b1, 8'h81, "post_reset");
      expect_grant(8'h01, "post_reset_ptr0");

      // no preemption
      step(1'b0, 1'b1, 8'h00, "np_reset");
      step(1'b1, 1'b1, 8'h40, "np_g6");
      step(1'b1, 1'b1, 8'h41, "np_req0a");
      expect_grant(8'h40, "np_hold6a");
      step(1'b1, 1'b1, 8'h41, "np_req0b");
      expect_grant(8'h40, "np_hold6b");
      step(1'b1, 1'b1, 8'h01, "np_drop6");
      expect_grant(8'h01, "np_grant0");

      // random phase, requests often held to exercise hold and timeout
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         e  = ($urandom_range(0, 15) != 0);
         rn = ($urandom_range(0, 59) != 0);
         step(rn, e, r, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
